// File: rtl/adc_sample_packer.sv
// ============================================================================
// Module      : adc_sample_packer
// Description : Packs a free-running ADC sample stream into PACK-sample
//               AXI-Stream words grouped into fixed-length frames (tlast on
//               the final word). A first-word-fall-through output FIFO
//               absorbs tready stalls; words arriving while it is full are
//               dropped and reported through the sticky overflow flag.
//               Optional macro ADC_PACK_DROP_CNT_EN adds a 32-bit saturating
//               drop counter output (drop_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_sample_packer #(
    parameter int DATA_WIDTH  = 16,
    parameter int PACK        = 4,
    parameter int FRAME_WORDS = 256,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       data_val,
    output logic [DATA_WIDTH*PACK-1:0] m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    input  logic                       ovf_clr,
    output logic                       overflow
`ifdef ADC_PACK_DROP_CNT_EN
    ,
    output logic [31:0]                drop_cnt
`endif
);

    localparam int c_WORD_W = DATA_WIDTH * PACK;
    localparam int c_LW     = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int c_WW     = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int c_AW     = $clog2(FIFO_DEPTH);

    localparam logic [c_LW-1:0] c_LANE_LAST = c_LW'(PACK - 1);
    localparam logic [c_WW-1:0] c_WORD_LAST = c_WW'(FRAME_WORDS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_STOP = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_LW-1:0]     r_lane_cnt;
    logic [c_WW-1:0]     r_word_cnt;
    logic [c_WORD_W-1:0] r_word;
    logic [c_WORD_W-1:0] w_word_nxt;

    logic                w_capture;
    logic                w_word_done;
    logic                w_frame_done;

    // Completed word staged for one cycle before it enters the FIFO
    logic                r_push_vld;
    logic [c_WORD_W-1:0] r_push_data;
    logic                r_push_last;

    // FIFO storage: MSB of each entry carries tlast
    logic [c_WORD_W:0]   r_mem [FIFO_DEPTH];
    logic [c_AW:0]       r_wr_ptr;
    logic [c_AW:0]       r_rd_ptr;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic [c_WORD_W:0]   w_head;

    // In IDLE a sample is only taken when it also starts a capture run
    assign w_capture    = data_val & ((r_state != c_IDLE) | en);
    assign w_word_done  = w_capture & (r_lane_cnt == c_LANE_LAST);
    assign w_frame_done = w_word_done & (r_word_cnt == c_WORD_LAST);

    // Merge the incoming sample into its lane of the word under assembly
    always_comb begin
        w_word_nxt = r_word;
        for (int i = 0; i < PACK; i++) begin
            if (r_lane_cnt == c_LW'(i)) begin
                w_word_nxt[i*DATA_WIDTH +: DATA_WIDTH] = data_in;
            end
        end
    end

    // Next-state logic: en is honoured at frame boundaries, frames never truncate
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_capture) begin
                    w_state_nxt = c_RUN;
                end
            end
            c_RUN: begin
                if (w_frame_done) begin
                    w_state_nxt = en ? c_RUN : c_IDLE;
                end else if (!en) begin
                    w_state_nxt = c_STOP;
                end
            end
            c_STOP: begin
                if (w_frame_done) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // State, lane/word counters, word assembly and push staging
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_lane_cnt  <= '0;
            r_word_cnt  <= '0;
            r_word      <= '0;
            r_push_vld  <= 1'b0;
            r_push_data <= '0;
            r_push_last <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_push_vld <= w_word_done;
            if (w_capture) begin
                r_word     <= w_word_nxt;
                r_lane_cnt <= w_word_done ? '0 : r_lane_cnt + 1'b1;
            end
            if (w_word_done) begin
                r_word_cnt  <= w_frame_done ? '0 : r_word_cnt + 1'b1;
                r_push_data <= w_word_nxt;
                r_push_last <= w_frame_done;
            end
        end
    end

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_pop   = ~w_empty & m_axis_tready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts
    assign w_push  = r_push_vld & (~w_full | w_pop);
    assign w_drop  = r_push_vld & w_full & ~w_pop;
    assign w_head  = r_mem[r_rd_ptr[c_AW-1:0]];

    // Outputs read zero while nothing is queued
    assign m_axis_tvalid = ~w_empty;
    assign m_axis_tdata  = w_empty ? '0 : w_head[c_WORD_W-1:0];
    assign m_axis_tlast  = ~w_empty & w_head[c_WORD_W];

    // FIFO storage write; contents are don't-care until the pointers cover them
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= {r_push_last, r_push_data};
        end
    end

    // FIFO pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Sticky overflow: a new drop takes priority over a clear request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (w_drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef ADC_PACK_DROP_CNT_EN
    // Saturating count of dropped words; cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (w_drop && (drop_cnt != 32'hFFFF_FFFF)) begin
            drop_cnt <= drop_cnt + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_adc_sample_packer.sv
// ============================================================================
// Module      : tb_adc_sample_packer
// Description : Self-checking bench for adc_sample_packer. A sample-level
//               reference model (sample queues, frame sample count, bounded
//               output queue) predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_adc_sample_packer;

    localparam int DW    = 16;
    localparam int PK    = 4;
    localparam int FW    = 4;
    localparam int DEPTH = 16;
    localparam int WW    = DW * PK;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [DW-1:0] data_in;
    logic          data_val;
    logic [WW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          ovf_clr;
    logic          overflow;
`ifdef ADC_PACK_DROP_CNT_EN
    logic [31:0]   drop_cnt;
`endif

    always #5 clk = ~clk;

    adc_sample_packer #(
        .DATA_WIDTH  (DW),
        .PACK        (PK),
        .FRAME_WORDS (FW),
        .FIFO_DEPTH  (DEPTH)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .data_in       (data_in),
        .data_val      (data_val),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .ovf_clr       (ovf_clr),
        .overflow      (overflow)
`ifdef ADC_PACK_DROP_CNT_EN
        ,
        .drop_cnt      (drop_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int pops     = 0;

    // Reference model state
    logic [WW:0]   exp_q[$];      // {tlast, word} in output order
    logic [DW-1:0] m_cur[$];      // samples of the word being collected
    bit            m_active;
    bit            m_stop;
    int            m_nsamp;
    bit            m_pend;
    logic [WW:0]   m_pend_word;
    bit            m_ovf;
    longint        m_drops;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        m_cur.delete();
        m_active = 1'b0;
        m_stop   = 1'b0;
        m_nsamp  = 0;
        m_pend   = 1'b0;
        m_ovf    = 1'b0;
        m_drops  = 0;
    endfunction

    function automatic void model_take(input logic [DW-1:0] s);
        logic [WW-1:0] w;
        m_cur.push_back(s);
        m_nsamp++;
        if (m_cur.size() == PK) begin
            for (int i = 0; i < PK; i++) w[i*DW +: DW] = m_cur[i];
            m_pend      = 1'b1;
            m_pend_word = {(m_nsamp == PK*FW), w};
            m_cur.delete();
            if (m_nsamp == PK*FW) begin
                m_nsamp = 0;
                if (m_stop) m_active = 1'b0;
            end
        end
    endfunction

    // One clock edge of the model, using the inputs present before the edge
    function automatic void model_step();
        bit drop;
        if (exp_q.size() > 0 && m_axis_tready) void'(exp_q.pop_front());
        drop = 1'b0;
        if (m_pend) begin
            if (exp_q.size() == DEPTH) drop = 1'b1;
            else exp_q.push_back(m_pend_word);
        end
        if (drop) begin
            m_ovf = 1'b1;
            m_drops++;
        end else if (ovf_clr) begin
            m_ovf = 1'b0;
        end
        m_pend = 1'b0;
        if (!m_active) begin
            if (data_val && en) begin
                m_active = 1'b1;
                m_stop   = 1'b0;
                model_take(data_in);
            end
        end else begin
            if (!en) m_stop = 1'b1;
            if (data_val) model_take(data_in);
        end
    endfunction

    function automatic bit drop_expected();
        return m_pend && (exp_q.size() == DEPTH) && !m_axis_tready;
    endfunction

    task automatic compare_outputs();
        chk("tvalid", m_axis_tvalid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            chk("tdata", m_axis_tdata, exp_q[0][WW-1:0]);
            chk("tlast", m_axis_tlast, exp_q[0][WW]);
        end else begin
            chk("tdata_idle", m_axis_tdata, 64'd0);
            chk("tlast_idle", m_axis_tlast, 64'd0);
        end
        chk("overflow", overflow, m_ovf);
`ifdef ADC_PACK_DROP_CNT_EN
        chk("drop_cnt", drop_cnt, m_drops);
`endif
    endtask

    task automatic tick();
        if (m_axis_tvalid && m_axis_tready) pops++;
        @(posedge clk);
        model_step();
        #1;
        compare_outputs();
    endtask

    task automatic idle(input int n);
        en = 1'b0; data_val = 1'b0; m_axis_tready = 1'b1; ovf_clr = 1'b0;
        repeat (n) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, m_axis_tvalid, 64'd0);
        chk({tag, "_tdata"},  m_axis_tdata,  64'd0);
        chk({tag, "_tlast"},  m_axis_tlast,  64'd0);
        chk({tag, "_ovf"},    overflow,      64'd0);
`ifdef ADC_PACK_DROP_CNT_EN
        chk({tag, "_drop"},   drop_cnt,      64'd0);
`endif
    endtask

    initial begin
        logic [DW-1:0] s0, s3;
        int  ndrop;
        bit  evt;

        rst_n = 1'b0; en = 1'b0; data_val = 1'b0; data_in = '0;
        m_axis_tready = 1'b0; ovf_clr = 1'b0;
        model_reset();
        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic packing with known samples and first-word latency
        en = 1'b1; m_axis_tready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            data_val = 1'b1;
            data_in  = DW'(i);
            en       = (i != 16);
            tick();
            if (i == 4) chk("latency_capture_edge", m_axis_tvalid, 64'd0);
            if (i == 5) begin
                chk("latency_push_edge", m_axis_tvalid, 64'd1);
                chk("first_word", m_axis_tdata, 64'h0004_0003_0002_0001);
            end
        end
        idle(4);

        // en falls after 5 samples: the frame still completes with 4 words
        pops = 0;
        en = 1'b1; m_axis_tready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            data_val = 1'b1;
            data_in  = DW'($urandom);
            en       = (i < 5);
            tick();
        end
        chk("disable_words", pops, 64'd4);
        chk("disable_idle", m_axis_tvalid, 64'd0);
        idle(4);

        // Backpressure: exactly FIFO_DEPTH words held with no loss
        pops = 0;
        m_axis_tready = 1'b0;
        for (int i = 0; i < DEPTH*PK; i++) begin
            data_val = 1'b1;
            data_in  = DW'($urandom);
            en       = (i != DEPTH*PK-1);
            tick();
        end
        data_val = 1'b0;
        repeat (2) tick();
        chk("bp_no_overflow", overflow, 64'd0);
        m_axis_tready = 1'b1;
        repeat (DEPTH + 4) tick();
        chk("bp_words", pops, DEPTH);

        // Overflow: 20 words into a stalled FIFO, clear coincides with 3rd drop
        ndrop = 0;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 20*PK; i++) begin
            data_val = 1'b1;
            data_in  = DW'($urandom);
            en       = (i != 20*PK-1);
            ovf_clr  = 1'b0;
            if (drop_expected()) begin
                ndrop++;
                if (ndrop == 3) ovf_clr = 1'b1;
            end
            tick();
            if (ovf_clr) begin
                chk("ovf_set_wins", overflow, 64'd1);
`ifdef ADC_PACK_DROP_CNT_EN
                chk("drop_cnt_three", drop_cnt, 64'd3);
`endif
            end
        end
        data_val = 1'b0; ovf_clr = 1'b0;
        tick();
        ovf_clr = 1'b1;
        tick();
        chk("ovf_cleared", overflow, 64'd0);
`ifdef ADC_PACK_DROP_CNT_EN
        chk("drop_cnt_kept", drop_cnt, 64'd4);
`endif
        idle(DEPTH + 4);

        // Full FIFO with push and pop on the same edge
        pops = 0; evt = 1'b0;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 20*PK; i++) begin
            data_val = 1'b1;
            data_in  = DW'($urandom);
            en       = (i != 20*PK-1);
            if (!evt && m_pend && exp_q.size() == DEPTH) begin
                m_axis_tready = 1'b1;
                evt = 1'b1;
                tick();
                chk("full_pop_no_ovf", overflow, 64'd0);
                chk("full_pop_valid", m_axis_tvalid, 64'd1);
            end else begin
                tick();
            end
        end
        chk("full_pop_event", evt, 64'd1);
        data_val = 1'b0; en = 1'b0;
        repeat (DEPTH + 8) tick();
        chk("full_pop_words", pops, 64'd20);
        chk("full_pop_ovf_final", overflow, 64'd0);

        // Reset mid-frame with two words queued and a partial word
        m_axis_tready = 1'b0; en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            data_val = 1'b1;
            data_in  = DW'($urandom);
            tick();
        end
        data_val = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        #2 rst_n = 1'b1;
        m_axis_tready = 1'b1;
        for (int i = 0; i < FW*PK; i++) begin
            data_val = 1'b1;
            data_in  = DW'($urandom);
            en       = (i != FW*PK-1);
            if (i == 0) s0 = data_in;
            if (i == 3) s3 = data_in;
            tick();
            if (i == 4) begin
                chk("post_reset_lane0", m_axis_tdata[DW-1:0], s0);
                chk("post_reset_lane3", m_axis_tdata[WW-1 -: DW], s3);
            end
        end
        idle(4);

        // Randomized traffic with bursty backpressure and en toggling
        for (int blk = 0; blk < 30; blk++) begin
            int rdy_pct;
            rdy_pct = ($urandom_range(0, 1) == 1) ? 90 : 10;
            for (int c = 0; c < 50; c++) begin
                en            = ($urandom_range(0, 99) < 85);
                data_val      = ($urandom_range(0, 99) < 75);
                data_in       = DW'($urandom);
                m_axis_tready = ($urandom_range(0, 99) < rdy_pct);
                ovf_clr       = ($urandom_range(0, 99) < 3);
                tick();
            end
        end

        // Let any open frame finish and drain
        en = 1'b0; ovf_clr = 1'b0; m_axis_tready = 1'b1;
        for (int i = 0; i < FW*PK + 4; i++) begin
            data_val = 1'b1;
            data_in  = DW'($urandom);
            tick();
        end
        data_val = 1'b0;
        repeat (DEPTH + 4) tick();
        chk("final_drain", m_axis_tvalid, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
